// File: rtl/gpsreceiver2_capture_if.sv
// Sample-stream, capture-control and ping-pong bank handshake bundle for gpsreceiver2_capture.
// The capture block takes the slave view; the stream/consumer side takes the master view.
interface gpsreceiver2_capture_if #(
  parameter int adr_width = 11,
  parameter int len_width = 16
);
  logic                 byte_stb;
  logic [7:0]           byte_dat;
  logic                 start;
  logic                 abort;
  logic [len_width-1:0] nbytes;
  logic [1:0]           bank_release;
  logic                 buf_we;
  logic                 buf_bank;
  logic [adr_width-1:0] buf_adr;
  logic [7:0]           buf_dat;
  logic [1:0]           bank_full;
  logic [adr_width:0]   last_level;
  logic [len_width-1:0] count;
  logic                 busy;
  logic                 overflow;
  logic                 irq;

  modport slave (
    input  byte_stb, byte_dat, start, abort, nbytes, bank_release,
    output buf_we, buf_bank, buf_adr, buf_dat, bank_full, last_level,
           count, busy, overflow, irq
  );

  modport master (
    output byte_stb, byte_dat, start, abort, nbytes, bank_release,
    input  buf_we, buf_bank, buf_adr, buf_dat, bank_full, last_level,
           count, busy, overflow, irq
  );
endinterface

// File: rtl/gpsreceiver2_capture.sv
// Capture sequencer: writes the IQ byte stream into a ping-pong sample RAM,
// hands full banks to the consumer, enforces capture length and flags overflow.
module gpsreceiver2_capture #(
  parameter int adr_width = 11,
  parameter int len_width = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  gpsreceiver2_capture_if.slave  cap
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [adr_width-1:0] ADR_LAST   = '1;
  localparam logic [adr_width:0]   BANK_BYTES = {1'b1, {adr_width{1'b0}}};

  logic [1:0]           r_state;
  logic                 r_bank;
  logic [adr_width-1:0] r_adr;
  logic [len_width-1:0] r_count;
  logic [1:0]           r_full;
  logic [adr_width:0]   r_level;
  logic                 r_ovf;
  logic                 r_we;
  logic                 r_wbank;
  logic [adr_width-1:0] r_wadr;
  logic [7:0]           r_wdat;

  logic                 w_run;
  logic                 w_accept;
  logic                 w_refuse;
  logic                 w_wrap;
  logic [adr_width-1:0] w_adr_nxt;
  logic [len_width-1:0] w_count_nxt;
  logic                 w_len_end;
  logic                 w_end;
  logic                 w_partial;
  logic [1:0]           w_bank_1h;
  logic [1:0]           w_set;
  logic [adr_width:0]   w_level_nxt;

  always_comb begin
    w_run       = (r_state == S_RUN);
    w_accept    = w_run && cap.byte_stb && !r_full[r_bank];
    w_refuse    = w_run && cap.byte_stb &&  r_full[r_bank];
    w_wrap      = w_accept && (r_adr == ADR_LAST);
    w_adr_nxt   = r_adr;
    if (w_accept)
      w_adr_nxt = w_wrap ? {adr_width{1'b0}} : r_adr + 1'b1;
    w_count_nxt = r_count;
    if (w_accept && (r_count != {len_width{1'b1}}))
      w_count_nxt = r_count + 1'b1;
    w_len_end   = w_accept && (cap.nbytes != '0) && (w_count_nxt == cap.nbytes);
    w_end       = w_run && (w_len_end || cap.abort);
    // A wrap already closed the bank and left adr at 0, so no partial close follows it.
    w_partial   = w_end && (w_adr_nxt != '0);
    w_bank_1h   = r_bank ? 2'b10 : 2'b01;
    w_set       = (w_wrap || w_partial) ? w_bank_1h : 2'b00;
    w_level_nxt = r_level;
    if (w_wrap)
      w_level_nxt = BANK_BYTES;
    else if (w_partial)
      w_level_nxt = {1'b0, w_adr_nxt};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_bank  <= 1'b0;
      r_adr   <= '0;
      r_count <= '0;
      r_full  <= 2'b00;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_we    <= 1'b0;
      r_wbank <= 1'b0;
      r_wadr  <= '0;
      r_wdat  <= 8'h00;
    end else begin
      r_we   <= w_accept;
      // Set beats release when the same bank is closed and released together.
      r_full <= (r_full & ~cap.bank_release) | w_set;
      if (w_accept) begin
        r_wdat  <= cap.byte_dat;
        r_wbank <= r_bank;
        r_wadr  <= r_adr;
      end
      case (r_state)
        S_IDLE: begin
          if (cap.start) begin
            r_state <= S_RUN;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_level <= '0;
            r_adr   <= '0;
            r_bank  <= 1'b0;
            r_wbank <= 1'b0;
            r_wadr  <= '0;
          end
        end
        S_RUN: begin
          r_adr   <= w_adr_nxt;
          r_count <= w_count_nxt;
          r_level <= w_level_nxt;
          if (w_wrap)
            r_bank <= ~r_bank;
          if (w_refuse)
            r_ovf <= 1'b1;
          if (w_end)
            r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cap.buf_we     = r_we;
  assign cap.buf_bank   = r_wbank;
  assign cap.buf_adr    = r_wadr;
  assign cap.buf_dat    = r_wdat;
  assign cap.bank_full  = r_full;
  assign cap.last_level = r_level;
  assign cap.count      = r_count;
  assign cap.busy       = (r_state == S_RUN);
  assign cap.overflow   = r_ovf;
  assign cap.irq        = (r_state == S_DONE);

endmodule

// File: tb/tb_gpsreceiver2_capture.sv
// Bench for gpsreceiver2_capture: vector table, directed multi-cycle sequences,
// and randomized traffic compared against a byte-count based reference model.
module tb_gpsreceiver2_capture;
  localparam int AW = 11;
  localparam int LW = 16;
  localparam int S  = 2048;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gpsreceiver2_capture_if #(.adr_width(AW), .len_width(LW)) cap ();

  gpsreceiver2_capture #(.adr_width(AW), .len_width(LW)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .cap       (cap)
  );

  int n_chk = 0;
  int n_pass = 0;
  int irq_cnt = 0;
  logic mchk = 1'b0;
  logic [15:0] nb = 16'd0;

  // reference model state: position in the capture is derived from the accepted-byte total
  int          m_state;
  int          m_nacc;
  logic        m_we, m_bank, m_ovf;
  logic [10:0] m_adr;
  logic [7:0]  m_dat;
  logic [1:0]  m_full;
  logic [11:0] m_lvl;
  logic [15:0] m_cnt;

  typedef struct packed {
    logic        stb;
    logic [7:0]  dat;
    logic        st;
    logic        ab;
    logic [1:0]  rel;
    logic [15:0] nb;
    logic        we;
    logic [10:0] adr;
    logic [7:0]  wdat;
    logic [1:0]  full;
    logic [11:0] lvl;
    logic [15:0] cnt;
    logic        busy;
    logic        irq;
  } vec_t;
  vec_t vtab [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({cap.buf_we, cap.buf_bank, cap.buf_adr, cap.buf_dat, cap.bank_full,
                cap.last_level, cap.count, cap.busy, cap.overflow, cap.irq});
  endfunction

  function automatic logic [63:0] model_out();
    return 64'({m_we, m_bank, m_adr, m_dat, m_full, m_lvl, m_cnt,
                (m_state == 1), m_ovf, (m_state == 2)});
  endfunction

  task automatic model_step(input logic stb, input logic [7:0] dat, input logic st,
                            input logic ab, input logic [1:0] rel, input logic rstn);
    logic [1:0] set;
    logic acc;
    int b;
    set = 2'b00;
    acc = 1'b0;
    if (!rstn) begin
      m_state = 0; m_nacc = 0; m_we = 0; m_bank = 0; m_ovf = 0;
      m_adr = '0; m_dat = '0; m_full = '0; m_lvl = '0; m_cnt = '0;
    end else begin
      m_we = 1'b0;
      case (m_state)
        0: if (st) begin
          m_state = 1; m_nacc = 0; m_cnt = '0; m_ovf = 0; m_lvl = '0;
          m_bank = 0; m_adr = '0;
        end
        2: m_state = 0;
        default: begin
          b = (m_nacc / S) % 2;
          if (stb) begin
            if (m_full[b]) m_ovf = 1'b1;
            else begin
              acc = 1'b1; m_we = 1'b1; m_bank = b[0];
              m_adr = 11'(m_nacc % S); m_dat = dat;
              m_nacc++;
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
              if (m_nacc % S == 0) begin set[b] = 1'b1; m_lvl = 12'(S); end
            end
          end
          if ((acc && nb != 0 && m_cnt == nb) || ab) begin
            if (m_nacc % S != 0) begin
              set[(m_nacc / S) % 2] = 1'b1;
              m_lvl = 12'(m_nacc % S);
            end
            m_state = 2;
          end
        end
      endcase
      m_full = (m_full & ~rel) | set;
    end
  endtask

  task automatic cyc(input logic stb, input logic [7:0] dat, input logic st,
                     input logic ab, input logic [1:0] rel, input logic rstn);
    cap.byte_stb = stb; cap.byte_dat = dat; cap.start = st; cap.abort = ab;
    cap.bank_release = rel; cap.nbytes = nb; rst_n = rstn;
    @(posedge clk);
    #1;
    model_step(stb, dat, st, ab, rel, rstn);
    if (cap.irq) irq_cnt++;
    if (mchk) chk("model", outs(), model_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    vtab[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 16'd3, 1'b0, 11'd0, 8'h00, 2'b00, 12'd0, 16'd0, 1'b1, 1'b0};
    vtab[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 2'b00, 16'd3, 1'b1, 11'd0, 8'hA5, 2'b00, 12'd0, 16'd1, 1'b1, 1'b0};
    vtab[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 16'd3, 1'b0, 11'd0, 8'hA5, 2'b00, 12'd0, 16'd1, 1'b1, 1'b0};
    vtab[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 2'b00, 16'd3, 1'b1, 11'd1, 8'h3C, 2'b00, 12'd0, 16'd2, 1'b1, 1'b0};
    vtab[4] = '{1'b1, 8'h7E, 1'b0, 1'b0, 2'b00, 16'd3, 1'b1, 11'd2, 8'h7E, 2'b01, 12'd3, 16'd3, 1'b0, 1'b1};
    vtab[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 16'd3, 1'b0, 11'd2, 8'h7E, 2'b01, 12'd3, 16'd3, 1'b0, 1'b0};
    vtab[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 16'd3, 1'b0, 11'd2, 8'h7E, 2'b00, 12'd3, 16'd3, 1'b0, 1'b0};
    vtab[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 16'd3, 1'b0, 11'd2, 8'h7E, 2'b00, 12'd3, 16'd3, 1'b0, 1'b0};
    vtab[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 16'd3, 1'b0, 11'd0, 8'h7E, 2'b00, 12'd0, 16'd0, 1'b1, 1'b0};
    vtab[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 16'd3, 1'b0, 11'd0, 8'h7E, 2'b00, 12'd0, 16'd0, 1'b0, 1'b1};

    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("reset_outputs", outs(), 64'd0);

    // vector table: latency, partial close on length end, ignored abort, restart
    for (int r = 0; r < 10; r++) begin
      nb = vtab[r].nb;
      cyc(vtab[r].stb, vtab[r].dat, vtab[r].st, vtab[r].ab, vtab[r].rel, 1'b1);
      chk($sformatf("vec%0d", r),
          64'({cap.buf_we, cap.buf_adr, cap.buf_dat, cap.bank_full, cap.last_level,
               cap.count, cap.busy, cap.irq}),
          64'({vtab[r].we, vtab[r].adr, vtab[r].wdat, vtab[r].full, vtab[r].lvl,
               vtab[r].cnt, vtab[r].busy, vtab[r].irq}));
    end
    idle(2);

    // 3000-byte capture with prompt consumer
    nb = 16'd3000; irq_cnt = 0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 2'b00, 1'b1);
      if (i == 2047) begin
        chk("a_bank0_full", 64'(cap.bank_full), 64'(2'b01));
        chk("a_level2048", 64'(cap.last_level), 64'd2048);
      end
      if (i == 2048) chk("a_second_bank_write", 64'({cap.buf_bank, cap.buf_adr}), 64'({1'b1, 11'd0}));
      if (i < 2999) for (int g = 0; g < 3; g++) cyc(1'b0, 8'h00, 1'b0, 1'b0, cap.bank_full, 1'b1);
    end
    chk("a_bank1_full", 64'(cap.bank_full), 64'(2'b10));
    chk("a_level952", 64'(cap.last_level), 64'd952);
    chk("a_count", 64'(cap.count), 64'd3000);
    chk("a_overflow", 64'(cap.overflow), 64'd0);
    idle(3);
    chk("a_irq_once", 64'(irq_cnt), 64'd1);

    // continuous capture without release: both banks fill, then bytes are dropped
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    nb = 16'd0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 4106; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 2'b00, 1'b1);
    chk("b_full_both", 64'(cap.bank_full), 64'(2'b11));
    chk("b_overflow", 64'(cap.overflow), 64'd1);
    chk("b_count4096", 64'(cap.count), 64'd4096);
    chk("b_busy", 64'(cap.busy), 64'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("b_resume_write", 64'({cap.buf_we, cap.buf_bank, cap.buf_adr, cap.buf_dat}),
        64'({1'b1, 1'b0, 11'd0, 8'h5A}));
    chk("b_count4097", 64'(cap.count), 64'd4097);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1);
    idle(2);

    // abort after 100 bytes, then a second abort
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 2'b00, 1'b1);
    irq_cnt = 0;
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1);
    chk("c_abort_state", 64'({cap.bank_full, cap.last_level, cap.irq, cap.busy}),
        64'({2'b01, 12'd100, 1'b1, 1'b0}));
    idle(2);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1);
    idle(2);
    chk("c_irq_once", 64'(irq_cnt), 64'd1);

    // close of bank0 coincides with its release: set wins
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 2047; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 2'b01, 1'b1);
    chk("d_set_wins", 64'({cap.bank_full[0], cap.buf_we, cap.buf_adr}), 64'({1'b1, 1'b1, 11'd2047}));
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1);
    idle(1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1);

    // reset in the middle of a capture
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 500; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("e_reset_mid_run", outs(), 64'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("e_restart_write", 64'({cap.buf_we, cap.buf_bank, cap.buf_adr, cap.buf_dat, cap.count}),
        64'({1'b1, 1'b0, 11'd0, 8'hAA, 16'd1}));

    // randomized traffic against the reference model, every cycle
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    mchk = 1'b1;
    for (int run = 0; run < 6; run++) begin
      nb = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 5000));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1);
      for (int c = 0; c < 3000 && cap.busy; c++)
        cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 799) == 0),
            {($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0)}, 1'b1);
      if (cap.busy) cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b1);
      idle(2);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
